// File: rtl/control_pipeline_if.sv
// ID-stage inputs and staged control outputs of the control pipeline.
// The block has no valid/ready handshake: every field is sampled on each clock edge it is not frozen.
interface control_pipeline_if #(
  parameter int REG_W = 5
);
  logic [6:0]       Op_i;
  logic [REG_W-1:0] rs1_i;
  logic [REG_W-1:0] rs2_i;
  logic [REG_W-1:0] rd_i;
  logic             stall_i;
  logic             flush_i;
  logic [2:0]       ex_ctrl_o;
  logic [2:0]       mem_ctrl_o;
  logic [1:0]       wb_ctrl_o;
  logic [REG_W-1:0] ex_rd_o;
  logic [REG_W-1:0] mem_rd_o;
  logic [REG_W-1:0] wb_rd_o;
  logic             hazard_o;
  logic             pc_write_o;
  logic             if_id_write_o;
  logic             illegal_o;

  modport master (
    output Op_i, rs1_i, rs2_i, rd_i, stall_i, flush_i,
    input  ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, ex_rd_o, mem_rd_o, wb_rd_o,
    input  hazard_o, pc_write_o, if_id_write_o, illegal_o
  );

  modport slave (
    input  Op_i, rs1_i, rs2_i, rd_i, stall_i, flush_i,
    output ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, ex_rd_o, mem_rd_o, wb_rd_o,
    output hazard_o, pc_write_o, if_id_write_o, illegal_o
  );
endinterface

// File: rtl/control_pipeline.sv
// Opcode decoder feeding ID/EX, EX/MEM and MEM/WB control registers,
// with load-use stall detection, flush bubbles, global freeze and a sticky illegal-opcode flag.
module control_pipeline #(
  parameter int REG_W       = 5,
  parameter bit LOAD_USE_EN = 1'b1,
  parameter bit RD0_IS_ZERO = 1'b1
) (
  input logic           clk_i,
  input logic           rst_i,
  control_pipeline_if.slave bus
);
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_NOP  = 7'b0000000;

  logic [2:0]       w_ex;
  logic [2:0]       w_mem;
  logic [1:0]       w_wb;
  logic [1:0]       w_wb_in;
  logic             w_rs1_used;
  logic             w_rs2_used;
  logic             w_illegal;
  logic             w_rd_live;
  logic             w_src_match;
  logic             w_hazard;

  logic [2:0]       r_idex_ex;
  logic [2:0]       r_idex_mem;
  logic [1:0]       r_idex_wb;
  logic [REG_W-1:0] r_idex_rd;
  logic [2:0]       r_exmem_mem;
  logic [1:0]       r_exmem_wb;
  logic [REG_W-1:0] r_exmem_rd;
  logic [1:0]       r_memwb_wb;
  logic [REG_W-1:0] r_memwb_rd;
  logic             r_illegal;

  always_comb begin
    w_ex       = 3'b000;
    w_mem      = 3'b000;
    w_wb       = 2'b00;
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    w_illegal  = 1'b0;
    case (bus.Op_i)
      OP_R:    begin w_ex = 3'b100; w_wb = 2'b10; w_rs1_used = 1'b1; w_rs2_used = 1'b1; end
      OP_LW:   begin w_ex = 3'b001; w_mem = 3'b010; w_wb = 2'b11; w_rs1_used = 1'b1; end
      OP_ADDI: begin w_ex = 3'b001; w_wb = 2'b10; w_rs1_used = 1'b1; end
      OP_SD:   begin w_ex = 3'b001; w_mem = 3'b001; w_rs1_used = 1'b1; w_rs2_used = 1'b1; end
      OP_BEQ:  begin w_ex = 3'b010; w_mem = 3'b100; w_rs1_used = 1'b1; w_rs2_used = 1'b1; end
      OP_NOP:  ;
      default: w_illegal = 1'b1;
    endcase
  end

  // A write to x0 is architecturally dead, so its RegWrite is dropped before it enters the pipe.
  assign w_wb_in     = {w_wb[1] & ~(RD0_IS_ZERO && (bus.rd_i == '0)), w_wb[0]};

  assign w_rd_live   = (r_idex_rd != '0) || !RD0_IS_ZERO;
  assign w_src_match = (w_rs1_used && (bus.rs1_i == r_idex_rd)) ||
                       (w_rs2_used && (bus.rs2_i == r_idex_rd));
  assign w_hazard    = LOAD_USE_EN && !bus.stall_i && !bus.flush_i &&
                       r_idex_mem[1] && w_rd_live && w_src_match;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idex_ex   <= '0;
      r_idex_mem  <= '0;
      r_idex_wb   <= '0;
      r_idex_rd   <= '0;
      r_exmem_mem <= '0;
      r_exmem_wb  <= '0;
      r_exmem_rd  <= '0;
      r_memwb_wb  <= '0;
      r_memwb_rd  <= '0;
      r_illegal   <= 1'b0;
    end else if (!bus.stall_i) begin
      if (bus.flush_i || w_hazard) begin
        r_idex_ex  <= '0;
        r_idex_mem <= '0;
        r_idex_wb  <= '0;
        r_idex_rd  <= '0;
      end else begin
        r_idex_ex  <= w_ex;
        r_idex_mem <= w_mem;
        r_idex_wb  <= w_wb_in;
        r_idex_rd  <= bus.rd_i;
      end
      r_exmem_mem <= r_idex_mem;
      r_exmem_wb  <= r_idex_wb;
      r_exmem_rd  <= r_idex_rd;
      r_memwb_wb  <= r_exmem_wb;
      r_memwb_rd  <= r_exmem_rd;
      // Only an opcode that actually advances into ID/EX may raise the sticky flag.
      if (!bus.flush_i && !w_hazard && w_illegal)
        r_illegal <= 1'b1;
    end
  end

  assign bus.ex_ctrl_o     = r_idex_ex;
  assign bus.mem_ctrl_o    = r_exmem_mem;
  assign bus.wb_ctrl_o     = r_memwb_wb;
  assign bus.ex_rd_o       = r_idex_rd;
  assign bus.mem_rd_o      = r_exmem_rd;
  assign bus.wb_rd_o       = r_memwb_rd;
  assign bus.hazard_o      = w_hazard;
  assign bus.pc_write_o    = !(bus.stall_i || w_hazard);
  assign bus.if_id_write_o = !(bus.stall_i || w_hazard);
  assign bus.illegal_o     = r_illegal;
endmodule

// File: tb/tb_control_pipeline.sv
// Directed-vector bench for control_pipeline: latency, load-use stall, x0 handling,
// flush, freeze, illegal-opcode stickiness and mid-stream reset.
module tb_control_pipeline;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_NOP  = 7'b0000000;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [23:0] exp_v;
  logic [2:0]  exp_h;

  always #5 clk = ~clk;

  control_pipeline_if #(.REG_W(5)) bus();

  control_pipeline #(.REG_W(5), .LOAD_USE_EN(1'b1), .RD0_IS_ZERO(1'b1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Observed staged state: {ex, mem, wb, ex_rd, mem_rd, wb_rd, illegal}
  function automatic logic [23:0] obs();
    return {bus.ex_ctrl_o, bus.mem_ctrl_o, bus.wb_ctrl_o,
            bus.ex_rd_o, bus.mem_rd_o, bus.wb_rd_o, bus.illegal_o};
  endfunction

  function automatic logic [2:0] obs_h();
    return {bus.hazard_o, bus.pc_write_o, bus.if_id_write_o};
  endfunction

  function automatic logic [23:0] ev(input logic [2:0] ex, input logic [2:0] mem,
                                     input logic [1:0] wb, input logic [4:0] exrd,
                                     input logic [4:0] memrd, input logic [4:0] wbrd,
                                     input logic ill);
    return {ex, mem, wb, exrd, memrd, wbrd, ill};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [6:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd);
    bus.Op_i  = op;
    bus.rs1_i = rs1;
    bus.rs2_i = rs2;
    bus.rd_i  = rd;
    #1;
  endtask

  task automatic drain();
    set_id(OP_NOP, 5'd0, 5'd0, 5'd0);
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_v = '0;
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL reset_state got=%h exp=%h", obs(), exp_v); end
    exp_h = 3'b011;
    n_tests++;
    if (obs_h() !== exp_h) begin n_fail++; $display("FAIL reset_enables got=%b exp=%b", obs_h(), exp_h); end
  endtask

  task automatic test_latency();
    set_id(OP_R, 5'd1, 5'd2, 5'd3);
    step();
    exp_v = ev(3'b100, 3'b000, 2'b00, 5'd3, 5'd0, 5'd0, 1'b0);
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL lat_ex got=%h exp=%h", obs(), exp_v); end
    set_id(OP_NOP, 5'd0, 5'd0, 5'd0);
    step();
    exp_v = ev(3'b000, 3'b000, 2'b00, 5'd0, 5'd3, 5'd0, 1'b0);
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL lat_mem got=%h exp=%h", obs(), exp_v); end
    step();
    exp_v = ev(3'b000, 3'b000, 2'b10, 5'd0, 5'd0, 5'd3, 1'b0);
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL lat_wb got=%h exp=%h", obs(), exp_v); end
  endtask

  task automatic test_load_use();
    drain();
    set_id(OP_LW, 5'd1, 5'd0, 5'd5);
    step();
    set_id(OP_R, 5'd1, 5'd5, 5'd6);
    exp_h = 3'b100;
    n_tests++;
    if (obs_h() !== exp_h) begin n_fail++; $display("FAIL lu_stall got=%b exp=%b", obs_h(), exp_h); end
    step();
    exp_v = ev(3'b000, 3'b010, 2'b00, 5'd0, 5'd5, 5'd0, 1'b0);
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL lu_bubble got=%h exp=%h", obs(), exp_v); end
    exp_h = 3'b011;
    n_tests++;
    if (obs_h() !== exp_h) begin n_fail++; $display("FAIL lu_release got=%b exp=%b", obs_h(), exp_h); end
    step();
    exp_v = ev(3'b100, 3'b000, 2'b11, 5'd6, 5'd0, 5'd5, 1'b0);
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL lu_resume got=%h exp=%h", obs(), exp_v); end
    // A load followed by addi naming the load's rd only as rs2 must not stall; sd must.
    set_id(OP_LW, 5'd1, 5'd0, 5'd7);
    step();
    set_id(OP_ADDI, 5'd1, 5'd7, 5'd8);
    exp_h = 3'b011;
    n_tests++;
    if (obs_h() !== exp_h) begin n_fail++; $display("FAIL lu_addi_rs2 got=%b exp=%b", obs_h(), exp_h); end
    set_id(OP_SD, 5'd1, 5'd7, 5'd8);
    exp_h = 3'b100;
    n_tests++;
    if (obs_h() !== exp_h) begin n_fail++; $display("FAIL lu_sd_rs2 got=%b exp=%b", obs_h(), exp_h); end
    drain();
  endtask

  task automatic test_rd0();
    set_id(OP_LW, 5'd1, 5'd0, 5'd0);
    step();
    set_id(OP_R, 5'd0, 5'd0, 5'd7);
    exp_h = 3'b011;
    n_tests++;
    if (obs_h() !== exp_h) begin n_fail++; $display("FAIL rd0_nostall got=%b exp=%b", obs_h(), exp_h); end
    step();
    exp_v = ev(3'b100, 3'b010, 2'b00, 5'd7, 5'd0, 5'd0, 1'b0);
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL rd0_adv got=%h exp=%h", obs(), exp_v); end
    set_id(OP_NOP, 5'd0, 5'd0, 5'd0);
    step();
    exp_v = ev(3'b000, 3'b000, 2'b01, 5'd0, 5'd7, 5'd0, 1'b0);
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL rd0_wb got=%h exp=%h", obs(), exp_v); end
    drain();
  endtask

  task automatic test_flush();
    set_id(OP_LW, 5'd1, 5'd0, 5'd4);
    step();
    bus.flush_i = 1'b1;
    set_id(OP_BEQ, 5'd4, 5'd2, 5'd0);
    exp_h = 3'b011;
    n_tests++;
    if (obs_h() !== exp_h) begin n_fail++; $display("FAIL flush_nohaz got=%b exp=%b", obs_h(), exp_h); end
    step();
    bus.flush_i = 1'b0;
    exp_v = ev(3'b000, 3'b010, 2'b00, 5'd0, 5'd4, 5'd0, 1'b0);
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL flush_bubble got=%h exp=%h", obs(), exp_v); end
    set_id(OP_NOP, 5'd0, 5'd0, 5'd0);
    step();
    exp_v = ev(3'b000, 3'b000, 2'b11, 5'd0, 5'd0, 5'd4, 1'b0);
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL flush_wb got=%h exp=%h", obs(), exp_v); end
    drain();
  endtask

  task automatic test_stall();
    set_id(OP_SD, 5'd1, 5'd2, 5'd8);
    step();
    set_id(OP_ADDI, 5'd1, 5'd0, 5'd9);
    step();
    set_id(OP_LW, 5'd1, 5'd0, 5'd10);
    step();
    bus.stall_i = 1'b1;
    set_id(OP_R, 5'd10, 5'd0, 5'd11);
    exp_h = 3'b000;
    n_tests++;
    if (obs_h() !== exp_h) begin n_fail++; $display("FAIL stall_enables got=%b exp=%b", obs_h(), exp_h); end
    exp_v = ev(3'b001, 3'b000, 2'b00, 5'd10, 5'd9, 5'd8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL stall_hold%0d got=%h exp=%h", i, obs(), exp_v); end
    end
    bus.stall_i = 1'b0;
    set_id(OP_NOP, 5'd0, 5'd0, 5'd0);
    step();
    exp_v = ev(3'b000, 3'b010, 2'b10, 5'd0, 5'd10, 5'd9, 1'b0);
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL stall_resume1 got=%h exp=%h", obs(), exp_v); end
    step();
    exp_v = ev(3'b000, 3'b000, 2'b11, 5'd0, 5'd0, 5'd10, 1'b0);
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL stall_resume2 got=%h exp=%h", obs(), exp_v); end
    drain();
  endtask

  task automatic test_illegal();
    bus.flush_i = 1'b1;
    set_id(OP_BAD, 5'd0, 5'd0, 5'd0);
    step();
    bus.flush_i = 1'b0;
    exp_v = '0;
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL ill_flushed got=%h exp=%h", obs(), exp_v); end
    bus.stall_i = 1'b1;
    step();
    bus.stall_i = 1'b0;
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL ill_stalled got=%h exp=%h", obs(), exp_v); end
    #1;
    step();
    exp_v = ev(3'b000, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0, 1'b1);
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL ill_set got=%h exp=%h", obs(), exp_v); end
    set_id(OP_NOP, 5'd0, 5'd0, 5'd0);
    step();
    step();
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL ill_sticky got=%h exp=%h", obs(), exp_v); end
    set_id(OP_LW, 5'd1, 5'd0, 5'd5);
    step();
    set_id(OP_ADDI, 5'd2, 5'd0, 5'd6);
    step();
    exp_v = ev(3'b001, 3'b010, 2'b00, 5'd6, 5'd5, 5'd0, 1'b1);
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL ill_inflight got=%h exp=%h", obs(), exp_v); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_v = '0;
    n_tests++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL mid_reset got=%h exp=%h", obs(), exp_v); end
  endtask

  initial begin
    bus.Op_i    = OP_NOP;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;
    bus.rd_i    = '0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    test_reset();
    test_latency();
    test_load_use();
    test_rd0();
    test_flush();
    test_stall();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
